port_req_queue: RTL
===================

Name: port_req_queue

Overview:
- Parametrised successor to the router's 4-port/4-deep request queue.
- Input ports raise a data-available request. The block queues requesting port numbers in arrival order and issues one grant at a time to the shared downstream sink when the sink is ready.
- New over the previous generation: N ports, D depth, same-cycle bypass, overflow detection, optional duplicate suppression, synchronous flush, occupancy output.

Parameters:
- NUM_PORTS, 4, number of requesting ports (≥2).
- DEPTH, 4, queue entries (≥2; need not be a power of 2).
- DEDUP, 0, when 1, a port already pending in the queue is not enqueued again.
- PORT_W, $clog2(NUM_PORTS), derived: port-number width.
- CNT_W, $clog2(DEPTH+1), derived: count width.

Ports:
- clk  in  1  clock
- rst_b  in  1  reset; asynchronous, active-low
- enq_valid  in  1  a port requests service this cycle
- enq_port  in  PORT_W  requesting port number
- enq_ready  out  1  request will be accepted (queued or bypassed) this cycle
- out_ready  in  1  downstream sink empty / able to take data
- grant  out  1  sink write strobe (wr_data equivalent)
- grant_port  out  PORT_W  mux select; valid only when grant=1, else 0
- clear_avail  out  NUM_PORTS  one-hot clear of the granted port's data-available flag; 0 when no grant
- flush  in  1  synchronous clear of queue contents
- clr_err  in  1  clears overflow_err
- count  out  CNT_W  current occupancy
- full  out  1  count==DEPTH
- overflow_err  out  1  sticky: a request was dropped because the queue was full

Behaviour:
- Reset (async): state=IDLE, head=tail=0, count=0, pending mask=0, overflow_err=0, all storage=0. Combinational outputs are therefore grant=0, clear_avail=0, grant_port=0, enq_ready=1.
- FSM states:
  - IDLE: queue empty, no grant outstanding.
  - SERVE: queue non-empty, sink may be granted.
  - HOLD: one-cycle guard after any grant. out_ready is ignored because the sink's status lags by one cycle.
- Grant condition (combinational, same cycle): state≠HOLD && out_ready && (count>0 || enq_valid).
  - If count>0: grant_port = entry at head; pop head.
  - Else (bypass): grant_port = enq_port; nothing is stored; 0-cycle latency.
- clear_avail[grant_port]=1 exactly when grant=1. All other bits are 0; outputs never float.
- Enqueue, evaluated when enq_valid and not bypassed:
  - accepted if count<DEPTH, or if a pop happens this cycle while full;
  - entry written at tail; tail advances.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Full with no pop: request dropped, enq_ready=0, overflow_err set next edge, count stays DEPTH.
- DEDUP=1: pending[p] is set on enqueue of p and cleared on pop of p.
  - enq_valid with pending[enq_port]=1 is absorbed: enq_ready=1, no write, no count change, no overflow.
  - Bypass grants never set pending.
- Pointer wrap: head/tail go DEPTH-1 → 0 (compare, not modulo), so non-power-of-2 DEPTH works.
- Transitions:
  - any grant → HOLD;
  - HOLD → SERVE if next count>0, else IDLE;
  - IDLE → SERVE on an accepted (non-bypassed) enqueue;
  - SERVE → IDLE only when count reaches 0.
- HOLD still accepts enqueues.
- flush (sync, highest priority after reset): head=tail=count=0, pending=0, state=IDLE. A grant computed in the flush cycle is suppressed (grant=0), and so is any enqueue. overflow_err is unaffected.
- clr_err clears overflow_err. If an overflow occurs in the same cycle, set wins.
- count must never exceed DEPTH. The bench asserts this.

Decomposition:
- Package port_q_pkg holds the state enum (IDLE, SERVE, HOLD) and a port-number typedef parameterised through the module.
- One sub-module, port_q_fifo: storage array, head/tail/count, push/pop/flush, full/empty.
- The top holds the FSM, bypass/grant logic, dedup mask and error flag.

Test Plan:
- Reset, then enq_valid port 2 with out_ready=1, state IDLE → same-cycle grant=1, grant_port=2, clear_avail=0100; count stays 0; next cycle state HOLD.
- out_ready=0; enqueue ports 2,1,0,3 on consecutive cycles → count=4, full=1. Then raise out_ready → grants 2,1,0,3 on every second cycle (HOLD between); count 3,2,1,0; final state IDLE.
- Full queue, out_ready=0, enq port 1 → enq_ready=0, count stays 4, overflow_err=1 next edge. clr_err → 0.
- Full queue, grant cycle with enq port 3 in the same cycle → count stays 4; port 3 is popped last after wrap (head 3→0).
- DEDUP=1, out_ready=0: enq 1,1,2 → count=2, enq_ready=1 each cycle, no overflow. After port 1 is popped, enq 1 is accepted again.
- Queue holding 3 entries, assert flush while out_ready=1 → grant=0 that cycle, count=0, state IDLE. A request next cycle is served by bypass.

Source files
------------

// File: rtl/port_q_pkg.sv
// ---------------------------------------------------------------------------
// port_q_pkg
//   Shared types for the port request queue:
//     q_state_e  - grant FSM states (IDLE, SERVE, HOLD)
//     ptr_width  - pointer width for a queue of a given depth
//   The port-number type itself (port_t) depends on NUM_PORTS. A package
//   cannot take parameters, so each module declares port_t from its own
//   PORT_W.
// ---------------------------------------------------------------------------
package port_q_pkg;

  // IDLE : queue empty, no grant outstanding
  // SERVE: queue holds at least one request
  // HOLD : one-cycle guard after a grant while the sink status catches up
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    HOLD  = 2'd2
  } q_state_e;

  // Width of a head/tail pointer addressing 'depth' entries (at least 1 bit).
  function automatic int ptr_width(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : port_q_pkg

// File: rtl/port_req_queue_if.sv
// ---------------------------------------------------------------------------
// port_req_queue_if
//   Request/grant bundle between the requesting ports, the shared sink and
//   the port request queue.
//     enq_valid/enq_port/enq_ready  - request side handshake
//     out_ready                     - sink can take data
//     grant/grant_port/clear_avail  - grant strobe, mux select, flag clear
//     flush/clr_err                 - queue flush, overflow flag clear
//     count/full/overflow_err       - status
//   master: the environment (ports + sink); slave: the queue.
// ---------------------------------------------------------------------------
interface port_req_queue_if #(
  parameter int NUM_PORTS = 4,
  parameter int DEPTH     = 4
);
  localparam int PORT_W = $clog2(NUM_PORTS);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic                 enq_valid;
  logic [PORT_W-1:0]    enq_port;
  logic                 enq_ready;
  logic                 out_ready;
  logic                 grant;
  logic [PORT_W-1:0]    grant_port;
  logic [NUM_PORTS-1:0] clear_avail;
  logic                 flush;
  logic                 clr_err;
  logic [CNT_W-1:0]     count;
  logic                 full;
  logic                 overflow_err;

  modport master (
    output enq_valid, enq_port, out_ready, flush, clr_err,
    input  enq_ready, grant, grant_port, clear_avail, count, full, overflow_err
  );

  modport slave (
    input  enq_valid, enq_port, out_ready, flush, clr_err,
    output enq_ready, grant, grant_port, clear_avail, count, full, overflow_err
  );

endinterface : port_req_queue_if

// File: rtl/port_q_fifo.sv
// ---------------------------------------------------------------------------
// port_q_fifo
//   Circular buffer of port numbers with occupancy count. Pointers wrap by
//   comparison against DEPTH-1, so any DEPTH >= 2 works.
//   Ports:
//     clk, rst_b   - clock, async active-low reset
//     push         - write push_data at tail (honoured if not full or popping)
//     pop          - drop the head entry (honoured if not empty)
//     flush        - synchronous empty; overrides push/pop
//     push_data    - entry to write
//     head_data    - entry at head (meaningful when not empty)
//     count        - occupancy, 0..DEPTH
//     full, empty  - occupancy flags
// ---------------------------------------------------------------------------
module port_q_fifo
  import port_q_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = ptr_width(DEPTH);
  typedef logic [PTR_W-1:0] ptr_t;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  ptr_t             head_q, head_d;
  ptr_t             tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[head_q];

  // The caller should never push into a full queue without popping, or pop
  // an empty one; gating here keeps count within 0..DEPTH regardless.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[tail_q] = push_data;
        tail_d        = ptr_inc(tail_q);
      end
      if (pop_ok) begin
        head_d = ptr_inc(head_q);
      end
      if (push_ok && !pop_ok) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop_ok && !push_ok) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule : port_q_fifo

// File: rtl/port_req_queue.sv
// ---------------------------------------------------------------------------
// port_req_queue
//   Queues requesting port numbers in arrival order and grants them one at a
//   time to a shared sink. An empty queue forwards a request straight to the
//   sink in the same cycle (bypass). After every grant the sink is ignored
//   for one cycle because its ready status lags by a cycle.
//   Parameters:
//     NUM_PORTS - requesting ports (>= 2)
//     DEPTH     - queue entries (>= 2, any value)
//     DEDUP     - 1: a port already waiting in the queue is not queued again
//   Ports:
//     clk, rst_b - clock, async active-low reset
//     bus        - port_req_queue_if slave modport:
//                  enq_valid/enq_port/enq_ready, out_ready, grant,
//                  grant_port, clear_avail, flush, clr_err, count, full,
//                  overflow_err
// ---------------------------------------------------------------------------
module port_req_queue
  import port_q_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DEPTH     = 4,
  parameter int DEDUP     = 0
) (
  input  logic              clk,
  input  logic              rst_b,
  port_req_queue_if.slave   bus
);

  localparam int PORT_W = $clog2(NUM_PORTS);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef logic [PORT_W-1:0] port_t;

  q_state_e             state_q, state_d;
  logic [NUM_PORTS-1:0] pending_q, pending_d;
  logic                 overflow_q, overflow_d;

  port_t                head_port;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;

  logic                 grant_ok;
  logic                 pop;
  logic                 bypass;
  logic                 grant;
  port_t                grant_port;
  logic [NUM_PORTS-1:0] clear_avail;
  logic                 dup;
  logic                 room;
  logic                 want_enq;
  logic                 push;
  logic                 drop;
  logic                 enq_ready;
  logic                 next_nonempty;

  port_q_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PORT_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_b     (rst_b),
    .push      (push),
    .pop       (pop),
    .flush     (bus.flush),
    .push_data (bus.enq_port),
    .head_data (head_port),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Grant and enqueue decode. Queued requests always win the grant over a
  // new request, so bypass only happens with an empty queue. A full queue
  // can still take a request in a cycle where it also pops.
  always_comb begin
    grant_ok = (state_q != HOLD) && bus.out_ready && !bus.flush;
    pop      = grant_ok && !fifo_empty;
    bypass   = grant_ok && fifo_empty && bus.enq_valid;
    grant    = pop || bypass;

    grant_port = '0;
    if (pop) begin
      grant_port = head_port;
    end else if (bypass) begin
      grant_port = bus.enq_port;
    end

    clear_avail = '0;
    if (grant) begin
      clear_avail[grant_port] = 1'b1;
    end

    dup       = (DEDUP != 0) && pending_q[bus.enq_port];
    room      = !fifo_full || pop;
    want_enq  = bus.enq_valid && !bypass && !bus.flush;
    push      = want_enq && !dup && room;
    drop      = want_enq && !dup && !room;
    enq_ready = !bus.flush && (room || dup);

    // Occupancy after this edge is non-zero if something is written, or if
    // something remains after a possible pop of the last entry.
    next_nonempty = push || (!fifo_empty && !(pop && (fifo_count == CNT_W'(1))));
  end

  // Next-state logic. Flush dominates; any grant forces the HOLD guard.
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else if (grant) begin
      state_d = HOLD;
    end else begin
      case (state_q)
        IDLE:    if (push) state_d = SERVE;
        SERVE:   if (!next_nonempty) state_d = IDLE;
        HOLD:    state_d = next_nonempty ? SERVE : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Pending mask mirrors which ports sit in the queue. A port can only be
  // pushed when not pending, so the pop-clear and push-set never collide.
  always_comb begin
    pending_d = '0;
    if (DEDUP != 0) begin
      pending_d = pending_q;
      if (bus.flush) begin
        pending_d = '0;
      end else begin
        if (pop) begin
          pending_d[head_port] = 1'b0;
        end
        if (push) begin
          pending_d[bus.enq_port] = 1'b1;
        end
      end
    end
  end

  // Sticky overflow flag; a drop in the same cycle as clr_err wins.
  always_comb begin
    overflow_d = overflow_q;
    if (bus.clr_err) begin
      overflow_d = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.enq_ready    = enq_ready;
  assign bus.grant        = grant;
  assign bus.grant_port   = grant_port;
  assign bus.clear_avail  = clear_avail;
  assign bus.count        = fifo_count;
  assign bus.full         = fifo_full;
  assign bus.overflow_err = overflow_q;

endmodule : port_req_queue
